// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared types and constants for the VGA timing generator:
//   - axis_timing_t : one axis worth of timing (active, front porch, sync,
//                     back porch, sync polarity)
//   - H_TIMING_DEFAULT / V_MODE0_DEFAULT / V_MODE1_DEFAULT : 640x480@60 and
//                     640x400@70 reference timings
//   - mode_e        : vertical timing mode selector
//   - axis_total / axis_fits : elaboration-time width check helpers
package vga_timing_pkg;

  // Field width of the timing struct; counters of width CW use the low bits.
  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] act;
    logic [TW-1:0] fp;
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
    logic          pol;
  } axis_timing_t;

  localparam axis_timing_t H_TIMING_DEFAULT = '{act: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48, pol: 1'b0};
  localparam axis_timing_t V_MODE0_DEFAULT  = '{act: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33, pol: 1'b0};
  localparam axis_timing_t V_MODE1_DEFAULT  = '{act: 16'd400, fp: 16'd12, sync: 16'd2,  bp: 16'd35, pol: 1'b1};

  typedef enum logic {
    MODE_480_60 = 1'b0,
    MODE_400_70 = 1'b1
  } mode_e;

  function automatic int axis_total(axis_timing_t t);
    return int'(t.act) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

  // True when the axis total is representable by a cw-bit counter.
  function automatic bit axis_fits(axis_timing_t t, int cw);
    return (cw > 0) && (cw <= TW) && (axis_total(t) < (1 << cw));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis: a wrapping position counter plus phase decode.
//   Phase order: active, front porch, sync, back porch.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   en             advance the counter by one position
//   tim            timing for this axis (may change at runtime)
//   cnt            current position
//   wrap           cnt is the last position of the axis
//   act_phase      cnt is inside the active phase
//   sync_level     sync output level for cnt, already at the polarity in tim.pol
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  axis_timing_t  tim,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          act_phase,
  output logic          sync_level
);

  logic [31:0] pos;
  logic [31:0] act_end;
  logic [31:0] sync_start;
  logic [31:0] sync_end;
  logic [31:0] last;

  always_comb begin
    pos        = 32'(cnt);
    act_end    = 32'(tim.act);
    sync_start = act_end + 32'(tim.fp);
    sync_end   = sync_start + 32'(tim.sync);
    last       = sync_end + 32'(tim.bp) - 32'd1;
  end

  assign wrap       = (pos == last);
  assign act_phase  = (pos < act_end);
  assign sync_level = ((pos >= sync_start) && (pos < sync_end)) ? tim.pol : ~tim.pol;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA sync generator with two runtime-selectable vertical timings
//   (mode 0 = 640x480@60, mode 1 = 640x400@70), pixel clock enable and
//   per-mode sync polarity. All outputs are registered from the counter
//   state of the same ce edge, so they are mutually aligned with one ce of
//   latency.
// Ports:
//   clk25, reset_n    pixel clock, synchronous active-low reset
//   ce                pixel enable
//   mode_sel          requested mode, taken only at the frame wrap
//   mode_active       mode currently in effect
//   x, y              pixel / line coordinates
//   in_display_area   inside the active picture
//   hsync, vsync      sync outputs at configured polarity
//   frame, line       one-clk25 strobes at (0, V_ACT) and x = H_ACT
//   frame_count       frame counter, present only with VGA_TIMING_FRAME_CNT_EN
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CW      = 10,
  parameter int   H_ACT   = int'(H_TIMING_DEFAULT.act),
  parameter int   H_FP    = int'(H_TIMING_DEFAULT.fp),
  parameter int   H_SYNC  = int'(H_TIMING_DEFAULT.sync),
  parameter int   H_BP    = int'(H_TIMING_DEFAULT.bp),
  parameter logic H_POL   = H_TIMING_DEFAULT.pol,
  parameter int   V_ACT0  = int'(V_MODE0_DEFAULT.act),
  parameter int   V_FP0   = int'(V_MODE0_DEFAULT.fp),
  parameter int   V_SYNC0 = int'(V_MODE0_DEFAULT.sync),
  parameter int   V_BP0   = int'(V_MODE0_DEFAULT.bp),
  parameter logic V_POL0  = V_MODE0_DEFAULT.pol,
  parameter int   V_ACT1  = int'(V_MODE1_DEFAULT.act),
  parameter int   V_FP1   = int'(V_MODE1_DEFAULT.fp),
  parameter int   V_SYNC1 = int'(V_MODE1_DEFAULT.sync),
  parameter int   V_BP1   = int'(V_MODE1_DEFAULT.bp),
  parameter logic V_POL1  = V_MODE1_DEFAULT.pol,
  parameter int   FCW     = 16
) (
  input  logic          clk25,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          mode_sel,
  output logic          mode_active,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          in_display_area,
  output logic          hsync,
  output logic          vsync,
  output logic          frame,
  output logic          line
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FCW-1:0] frame_count
`endif
);

  localparam axis_timing_t H_TIM  = '{act: TW'(H_ACT),  fp: TW'(H_FP),  sync: TW'(H_SYNC),  bp: TW'(H_BP),  pol: H_POL};
  localparam axis_timing_t V0_TIM = '{act: TW'(V_ACT0), fp: TW'(V_FP0), sync: TW'(V_SYNC0), bp: TW'(V_BP0), pol: V_POL0};
  localparam axis_timing_t V1_TIM = '{act: TW'(V_ACT1), fp: TW'(V_FP1), sync: TW'(V_SYNC1), bp: TW'(V_BP1), pol: V_POL1};

  if (!axis_fits(H_TIM, CW) || !axis_fits(V0_TIM, CW) || !axis_fits(V1_TIM, CW) || (FCW < 1)) begin : g_bad_cfg
    $error("vga_timing_gen: a line or frame total does not fit in CW bits");
  end

  mode_e          mode_q;
  axis_timing_t   v_tim;
  logic [CW-1:0]  hcnt;
  logic [CW-1:0]  vcnt;
  logic           h_wrap, v_wrap;
  logic           h_act, v_act;
  logic           h_sync_level, v_sync_level;
  logic           v_en;
  logic           frame_hit;
  logic           line_hit;

  // The vertical timing follows mode_q, which only moves at the frame wrap,
  // so a frame always completes with the timing it started with.
  assign v_tim = (mode_q == MODE_400_70) ? V1_TIM : V0_TIM;
  assign v_en  = ce & h_wrap;

  vga_axis_counter #(.CW(CW)) u_h_axis (
    .clk        (clk25),
    .reset_n    (reset_n),
    .en         (ce),
    .tim        (H_TIM),
    .cnt        (hcnt),
    .wrap       (h_wrap),
    .act_phase  (h_act),
    .sync_level (h_sync_level)
  );

  vga_axis_counter #(.CW(CW)) u_v_axis (
    .clk        (clk25),
    .reset_n    (reset_n),
    .en         (v_en),
    .tim        (v_tim),
    .cnt        (vcnt),
    .wrap       (v_wrap),
    .act_phase  (v_act),
    .sync_level (v_sync_level)
  );

  // Strobes include ce so they drop to 0 on every ce=0 cycle.
  assign frame_hit = ce && (hcnt == '0) && (32'(vcnt) == 32'(v_tim.act));
  assign line_hit  = ce && (32'(hcnt) == 32'(H_TIM.act));

  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      mode_q          <= MODE_480_60;
      x               <= '0;
      y               <= '0;
      in_display_area <= 1'b0;
      hsync           <= ~H_TIM.pol;
      vsync           <= ~V0_TIM.pol;
      frame           <= 1'b0;
      line            <= 1'b0;
    end else begin
      frame <= frame_hit;
      line  <= line_hit;
      if (ce) begin
        x               <= hcnt;
        y               <= vcnt;
        in_display_area <= h_act & v_act;
        hsync           <= h_sync_level;
        vsync           <= v_sync_level;
        if (h_wrap && v_wrap) begin
          mode_q <= mode_e'(mode_sel);
        end
      end
    end
  end

  assign mode_active = mode_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk25) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_hit) begin
      frame_count <= frame_count + FCW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Self-checking bench for vga_timing_gen using reduced timings so that
//   whole frames fit in a short run. The reference model tracks a linear
//   pixel index within the frame and derives coordinates, phases and strobes
//   from it arithmetically. Inputs change on the falling edge; outputs are
//   sampled on the falling edge after each rising edge.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int   CW      = 8;
  localparam int   H_ACT   = 8;
  localparam int   H_FP    = 2;
  localparam int   H_SYNC  = 3;
  localparam int   H_BP    = 2;
  localparam logic H_POL   = 1'b0;
  localparam int   V_ACT0  = 6;
  localparam int   V_FP0   = 1;
  localparam int   V_SYNC0 = 2;
  localparam int   V_BP0   = 2;
  localparam logic V_POL0  = 1'b0;
  localparam int   V_ACT1  = 4;
  localparam int   V_FP1   = 2;
  localparam int   V_SYNC1 = 1;
  localparam int   V_BP1   = 3;
  localparam logic V_POL1  = 1'b1;
  localparam int   FCW     = 2;

  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT0 = V_ACT0 + V_FP0 + V_SYNC0 + V_BP0;
  localparam int V_TOT1 = V_ACT1 + V_FP1 + V_SYNC1 + V_BP1;
  localparam int VW     = 2 * CW + 6;

  // ---------------- clock / reset ----------------
  logic clk25    = 1'b0;
  logic reset_n  = 1'b0;
  logic ce       = 1'b0;
  logic mode_sel = 1'b0;
  always #5 clk25 = ~clk25;

  logic          mode_active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          in_display_area;
  logic          hsync;
  logic          vsync;
  logic          frame;
  logic          line;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] frame_count;
`endif

  vga_timing_gen #(
    .CW(CW), .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_POL(H_POL),
    .V_ACT0(V_ACT0), .V_FP0(V_FP0), .V_SYNC0(V_SYNC0), .V_BP0(V_BP0), .V_POL0(V_POL0),
    .V_ACT1(V_ACT1), .V_FP1(V_FP1), .V_SYNC1(V_SYNC1), .V_BP1(V_BP1), .V_POL1(V_POL1),
    .FCW(FCW)
  ) dut (
    .clk25           (clk25),
    .reset_n         (reset_n),
    .ce              (ce),
    .mode_sel        (mode_sel),
    .mode_active     (mode_active),
    .x               (x),
    .y               (y),
    .in_display_area (in_display_area),
    .hsync           (hsync),
    .vsync           (vsync),
    .frame           (frame),
    .line            (line)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_count     (frame_count)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [VW-1:0] exp_q[$];

  int            m_pix  = 0;
  logic          m_mode = 1'b0;
  logic [CW-1:0] e_x    = '0;
  logic [CW-1:0] e_y    = '0;
  logic          e_disp = 1'b0;
  logic          e_hs   = ~H_POL;
  logic          e_vs   = ~V_POL0;
  logic          e_fr   = 1'b0;
  logic          e_ln   = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] m_fc  = '0;
`endif

  localparam logic [VW-1:0] RST_VEC = {1'b0, {CW{1'b0}}, {CW{1'b0}}, 1'b0, ~H_POL, ~V_POL0, 1'b0, 1'b0};

  function automatic logic [VW-1:0] dut_vec();
    return {mode_active, x, y, in_display_area, hsync, vsync, frame, line};
  endfunction

  // Expected outputs after one rising edge, from the inputs applied to it.
  task automatic model_edge();
    int hc, vc, va, vf, vs, vt;
    logic vp;
    if (!reset_n) begin
      m_pix = 0; m_mode = 1'b0;
      e_x = '0; e_y = '0; e_disp = 1'b0; e_hs = ~H_POL; e_vs = ~V_POL0;
      e_fr = 1'b0; e_ln = 1'b0;
`ifdef VGA_TIMING_FRAME_CNT_EN
      m_fc = '0;
`endif
    end else begin
      e_fr = 1'b0;
      e_ln = 1'b0;
      if (ce) begin
        va = m_mode ? V_ACT1  : V_ACT0;
        vf = m_mode ? V_FP1   : V_FP0;
        vs = m_mode ? V_SYNC1 : V_SYNC0;
        vt = m_mode ? V_TOT1  : V_TOT0;
        vp = m_mode ? V_POL1  : V_POL0;
        hc = m_pix % H_TOT;
        vc = m_pix / H_TOT;
        e_x    = CW'(hc);
        e_y    = CW'(vc);
        e_disp = (hc < H_ACT) && (vc < va);
        e_hs   = (hc >= H_ACT + H_FP && hc < H_ACT + H_FP + H_SYNC) ? H_POL : ~H_POL;
        e_vs   = (vc >= va + vf && vc < va + vf + vs) ? vp : ~vp;
        e_fr   = (hc == 0) && (vc == va);
        e_ln   = (hc == H_ACT);
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (e_fr) m_fc = m_fc + FCW'(1);
`endif
        m_pix = m_pix + 1;
        if (m_pix == H_TOT * vt) begin
          m_pix  = 0;
          m_mode = mode_sel;
        end
      end
    end
    exp_q.push_back({m_mode, e_x, e_y, e_disp, e_hs, e_vs, e_fr, e_ln});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rst_v, input logic ce_v, input logic ms_v);
    reset_n  = rst_v;
    ce       = ce_v;
    mode_sel = ms_v;
    @(posedge clk25);
    model_edge();
    @(negedge clk25);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'($urandom), 1'($urandom));
    cycle(1'b0, 1'($urandom), 1'($urandom));
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] ev, av;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'($urandom), 1'($urandom));
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== RST_VEC) begin
        n_fail++;
        $display("FAIL reset_const cyc %0d: got %h expected %h", i, av, RST_VEC);
      end
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL reset_model cyc %0d: got %h expected %h", i, av, ev);
      end
    end
  endtask

  task automatic test_mode0();
    logic [VW-1:0] ev, av;
    int last_line = -1;
    int last_frame = -1;
    int n_frames = 0;
    do_reset();
    for (int i = 0; i < 2 * H_TOT * V_TOT0 + 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL mode0 cyc %0d: got %h expected %h", i, av, ev);
      end
      if (line) begin
        if (last_line >= 0) begin
          n_checks++;
          if (i - last_line != H_TOT) begin
            n_fail++;
            $display("FAIL mode0_line_period: got %0d expected %0d", i - last_line, H_TOT);
          end
        end
        last_line = i;
      end
      if (frame) begin
        if (last_frame >= 0) begin
          n_checks++;
          if (i - last_frame != H_TOT * V_TOT0) begin
            n_fail++;
            $display("FAIL mode0_frame_period: got %0d expected %0d", i - last_frame, H_TOT * V_TOT0);
          end
        end
        last_frame = i;
        n_frames++;
      end
    end
    n_checks++;
    if (n_frames != 2) begin
      n_fail++;
      $display("FAIL mode0_frame_count: got %0d expected 2", n_frames);
    end
  endtask

  task automatic test_mode1();
    logic [VW-1:0] ev, av;
    int frames[$];
    int bad_disp = 0;
    do_reset();
    for (int i = 0; i < H_TOT * V_TOT0 + 2 * H_TOT * V_TOT1 + 20; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL mode1 cyc %0d: got %h expected %h", i, av, ev);
      end
      if (frame) frames.push_back(i);
      if (mode_active && in_display_area && (int'(y) >= V_ACT1)) bad_disp++;
    end
    n_checks++;
    if (frames.size() != 3) begin
      n_fail++;
      $display("FAIL mode1_frames_seen: got %0d expected 3", frames.size());
    end else begin
      n_checks++;
      if (frames[2] - frames[1] != H_TOT * V_TOT1) begin
        n_fail++;
        $display("FAIL mode1_frame_period: got %0d expected %0d", frames[2] - frames[1], H_TOT * V_TOT1);
      end
    end
    n_checks++;
    if (bad_disp != 0) begin
      n_fail++;
      $display("FAIL mode1_display_area: got %0d cycles in display below active lines, expected 0", bad_disp);
    end
  endtask

  task automatic test_mode_switch();
    logic [VW-1:0] ev, av;
    int to_one = -1;
    int to_zero = -1;
    do_reset();
    for (int i = 0; i < H_TOT * V_TOT0 + H_TOT * V_TOT1 + 30; i++) begin
      cycle(1'b1, 1'b1, (i >= 3 * H_TOT) && (i < H_TOT * V_TOT0 + 40));
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL mode_switch cyc %0d: got %h expected %h", i, av, ev);
      end
      if (mode_active && to_one < 0) to_one = i;
      if (!mode_active && to_one >= 0 && to_zero < 0) to_zero = i;
    end
    n_checks++;
    if (to_one != H_TOT * V_TOT0 - 1) begin
      n_fail++;
      $display("FAIL mode_switch_to1: got edge %0d expected %0d", to_one, H_TOT * V_TOT0 - 1);
    end
    n_checks++;
    if (to_zero != H_TOT * V_TOT0 + H_TOT * V_TOT1 - 1) begin
      n_fail++;
      $display("FAIL mode_switch_to0: got edge %0d expected %0d", to_zero, H_TOT * V_TOT0 + H_TOT * V_TOT1 - 1);
    end
  endtask

  task automatic test_ce_half();
    logic [VW-1:0] ev, av;
    int last_line = -1;
    do_reset();
    for (int i = 0; i < 8 * H_TOT; i++) begin
      cycle(1'b1, (i % 2) == 0, 1'b0);
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL ce_half cyc %0d: got %h expected %h", i, av, ev);
      end
      if (line) begin
        if (last_line >= 0) begin
          n_checks++;
          if (i - last_line != 2 * H_TOT) begin
            n_fail++;
            $display("FAIL ce_half_line_period: got %0d expected %0d", i - last_line, 2 * H_TOT);
          end
        end
        last_line = i;
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] ev, av;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", i, av, ev);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] ev, av;
    do_reset();
    for (int i = 0; i < H_TOT * V_TOT0 + 3 * H_TOT + 5 + 31; i++) begin
      if (i == H_TOT * V_TOT0 + 3 * H_TOT + 5) cycle(1'b0, 1'b1, 1'b1);
      else cycle(1'b1, 1'b1, 1'b1);
      ev = exp_q.pop_front();
      av = dut_vec();
      n_checks++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", i, av, ev);
      end
      if (i == H_TOT * V_TOT0 + 3 * H_TOT + 5) begin
        n_checks++;
        if (av !== RST_VEC) begin
          n_fail++;
          $display("FAIL reset_mid_const: got %h expected %h", av, RST_VEC);
        end
      end
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_count();
    int seq[5] = '{1, 2, 3, 0, 1};
    int k = 0;
    logic pending = 1'b0;
    do_reset();
    for (int i = 0; i < 5 * H_TOT * V_TOT0 + 100; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      n_checks++;
      if (frame_count !== m_fc) begin
        n_fail++;
        $display("FAIL frame_count_model cyc %0d: got %0d expected %0d", i, frame_count, m_fc);
      end
      if (pending) begin
        n_checks++;
        if (int'(frame_count) != seq[k]) begin
          n_fail++;
          $display("FAIL frame_count_seq %0d: got %0d expected %0d", k, frame_count, seq[k]);
        end
        k++;
        pending = 1'b0;
      end
      if (frame && k < 5) pending = 1'b1;
    end
    n_checks++;
    if (k != 5) begin
      n_fail++;
      $display("FAIL frame_count_strobes: got %0d expected 5", k);
    end
    cycle(1'b0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    n_checks++;
    if (frame_count !== '0) begin
      n_fail++;
      $display("FAIL frame_count_reset: got %0d expected 0", frame_count);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk25);
    test_reset();
    test_mode0();
    test_mode1();
    test_mode_switch();
    test_ce_half();
    test_reset_mid();
    test_random();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
